// File: rtl/cntr_bs_datapath.sv
// rtl/cntr_bs_datapath.sv - bank-scheduler request FIFOs with head/row visibility for row-hit arbitration
module cntr_bs_datapath #(
    parameter int   RD_FIFO_NUM  = 4,
    parameter int   WR_FIFO_NUM  = 3,
    parameter int   RD_FIFO_SIZE = 4,
    parameter int   WR_FIFO_SIZE = 2,
    parameter int   DQ           = 16,
    parameter int   IDX          = 6,
    parameter int   RA           = 16,
    parameter int   CA           = 10,
    parameter int   RA_POS       = 14,
    parameter logic READ         = 1'b0,
    parameter logic WRITE        = 1'b1,
    localparam int  FIFO_NUM     = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int  BURST        = RA + CA - 4,
    localparam int  RA_ALL       = RA * FIFO_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FIFO_NUM-1:0]       push,
    input  logic [FIFO_NUM-1:0]       pop,
    input  logic                      valid_i,
    input  logic [DQ-1:0]             dq_i,
    input  logic [IDX-1:0]            idx_i,
    input  logic [RA-1:0]             ra_i,
    input  logic [CA-1:0]             ca_i,
    output logic [RA_ALL-1:0]         last_ra,
    output logic [FIFO_NUM-1:0]       full,
    output logic [FIFO_NUM-1:0]       mid,
    output logic [FIFO_NUM-1:0]       empty,
    output logic [DQ-1:0]             dq_o,
    output logic [IDX-1:0]            idx_o,
    output logic [RA-1:0]             ra_o,
    output logic [CA-1:0]             ca_o,
    output logic                      type_o,
    output logic [FIFO_NUM*BURST-1:0] first_burst,
    output logic                      grant
);
    localparam int MAX_SIZE = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE;
    localparam int PW       = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int CW       = $clog2(MAX_SIZE + 1);

    logic [FIFO_NUM*DQ-1:0]  head_dq;
    logic [FIFO_NUM*IDX-1:0] head_idx;
    logic [FIFO_NUM*RA-1:0]  head_ra;
    logic [FIFO_NUM*CA-1:0]  head_ca;

    logic [FIFO_NUM-1:0] pop_ok;
    logic                served;
    logic                found;
    logic                sel_wr;
    logic [DQ-1:0]       sel_dq;
    logic [IDX-1:0]      sel_idx;
    logic [RA-1:0]       sel_ra;
    logic [CA-1:0]       sel_ca;

    // RA_POS only describes the packed request layout upstream; nothing here depends on it.
    if (RA_POS >= IDX + RA + CA) begin : g_ra_pos_outside_request
    end

    // Lowest requested FIFO wins; an empty winner means nothing is served this cycle.
    always_comb begin
        pop_ok  = '0;
        served  = 1'b0;
        found   = 1'b0;
        sel_wr  = READ;
        sel_dq  = '0;
        sel_idx = '0;
        sel_ra  = '0;
        sel_ca  = '0;
        for (int i = 0; i < FIFO_NUM; i++) begin
            if (pop[i] && !found) begin
                found = 1'b1;
                if (!empty[i]) begin
                    pop_ok[i] = 1'b1;
                    served    = 1'b1;
                    sel_wr    = (i >= RD_FIFO_NUM) ? WRITE : READ;
                    sel_dq    = head_dq[i*DQ +: DQ];
                    sel_idx   = head_idx[i*IDX +: IDX];
                    sel_ra    = head_ra[i*RA +: RA];
                    sel_ca    = head_ca[i*CA +: CA];
                end
            end
        end
    end

    for (genvar g = 0; g < FIFO_NUM; g++) begin : g_fifo
        localparam int SIZE = (g < RD_FIFO_NUM) ? RD_FIFO_SIZE : WR_FIFO_SIZE;

        logic [IDX-1:0] mem_idx [MAX_SIZE];
        logic [RA-1:0]  mem_ra  [MAX_SIZE];
        logic [CA-1:0]  mem_ca  [MAX_SIZE];
        logic [PW-1:0]  wr_ptr;
        logic [PW-1:0]  rd_ptr;
        logic [CW-1:0]  count;
        logic [RA-1:0]  last_q;
        logic           push_ok;

        // A full FIFO still accepts a push when its head leaves on the same edge.
        assign push_ok  = push[g] & valid_i & (~full[g] | pop_ok[g]);
        assign empty[g] = (count == '0);
        assign full[g]  = (count == CW'(SIZE));
        assign mid[g]   = (count >= CW'(SIZE / 2));

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem_idx[wr_ptr] <= idx_i;
                mem_ra[wr_ptr]  <= ra_i;
                mem_ca[wr_ptr]  <= ca_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                last_q <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= (wr_ptr == PW'(SIZE - 1)) ? '0 : wr_ptr + 1'b1;
                    last_q <= ra_i;
                end
                if (pop_ok[g]) begin
                    rd_ptr <= (rd_ptr == PW'(SIZE - 1)) ? '0 : rd_ptr + 1'b1;
                end
                count <= count + CW'(push_ok) - CW'(pop_ok[g]);
            end
        end

        if (g >= RD_FIFO_NUM) begin : g_wr
            logic [DQ-1:0] mem_dq [MAX_SIZE];
            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem_dq[wr_ptr] <= dq_i;
                end
            end
            assign head_dq[g*DQ +: DQ] = mem_dq[rd_ptr];
        end else begin : g_rd
            assign head_dq[g*DQ +: DQ] = '0;
        end

        assign head_idx[g*IDX +: IDX]      = mem_idx[rd_ptr];
        assign head_ra[g*RA +: RA]         = mem_ra[rd_ptr];
        assign head_ca[g*CA +: CA]         = mem_ca[rd_ptr];
        assign first_burst[g*BURST +: BURST] =
            empty[g] ? '0 : {mem_ra[rd_ptr], mem_ca[rd_ptr][CA-1:4]};
        assign last_ra[g*RA +: RA]         = last_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dq_o   <= '0;
            idx_o  <= '0;
            ra_o   <= '0;
            ca_o   <= '0;
            type_o <= READ;
            grant  <= 1'b0;
        end else begin
            grant <= served;
            if (served) begin
                dq_o   <= sel_dq;
                idx_o  <= sel_idx;
                ra_o   <= sel_ra;
                ca_o   <= sel_ca;
                type_o <= sel_wr;
            end
        end
    end
endmodule

// File: tb/tb_cntr_bs_datapath.sv
// tb/tb_cntr_bs_datapath.sv - scoreboard bench for cntr_bs_datapath
module tb_cntr_bs_datapath;
    typedef struct packed {
        logic [15:0] dq;
        logic [5:0]  idx;
        logic [15:0] ra;
        logic [9:0]  ca;
    } entry_t;
    typedef struct packed {
        logic   typ;
        entry_t e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [6:0]   push, pop;
    logic         valid_i;
    logic [15:0]  dq_i;
    logic [5:0]   idx_i;
    logic [15:0]  ra_i;
    logic [9:0]   ca_i;
    logic [111:0] last_ra;
    logic [6:0]   full, mid, empty;
    logic [15:0]  dq_o;
    logic [5:0]   idx_o;
    logic [15:0]  ra_o;
    logic [9:0]   ca_o;
    logic         type_o;
    logic [153:0] first_burst;
    logic         grant;

    entry_t mq [7][$];
    exp_t   sb [$];
    exp_t   mon_x;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    cntr_bs_datapath dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .valid_i(valid_i),
        .dq_i(dq_i), .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i),
        .last_ra(last_ra), .full(full), .mid(mid), .empty(empty),
        .dq_o(dq_o), .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o), .type_o(type_o),
        .first_burst(first_burst), .grant(grant)
    );

    // Every granted output is matched against the oldest expected pop.
    always @(negedge clk) begin
        if (grant === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_grant: got grant=1, required no pending pop");
            end else begin
                mon_x = sb.pop_front();
                if ({type_o, dq_o, idx_o, ra_o, ca_o} !== mon_x) begin
                    failures++;
                    $display("FAIL sb_pop_data: got %h required %h",
                             {type_o, dq_o, idx_o, ra_o, ca_o}, mon_x);
                end
            end
        end
    end

    function automatic entry_t mk(input logic [15:0] dq, input logic [5:0] idx,
                                  input logic [15:0] ra, input logic [9:0] ca);
        entry_t e;
        e.dq = dq; e.idx = idx; e.ra = ra; e.ca = ca;
        return e;
    endfunction

    function automatic int fsize(input int i);
        return (i < 4) ? 4 : 2;
    endfunction

    task automatic op(input logic [6:0] pu, input logic [6:0] po, input entry_t e, input logic v);
        int   served;
        logic found;
        exp_t x;
        served = -1;
        found  = 1'b0;
        push = pu; pop = po; valid_i = v;
        dq_i = e.dq; idx_i = e.idx; ra_i = e.ra; ca_i = e.ca;
        for (int i = 0; i < 7; i++) begin
            if (po[i] && !found) begin
                found = 1'b1;
                if (mq[i].size() > 0) served = i;
            end
        end
        if (served >= 0) begin
            x.e   = mq[served].pop_front();
            x.typ = (served >= 4);
            if (served < 4) x.e.dq = '0;
            sb.push_back(x);
        end
        for (int i = 0; i < 7; i++) begin
            if (pu[i] && v && mq[i].size() < fsize(i)) mq[i].push_back(e);
        end
        @(posedge clk);
        #2;
        push = '0; pop = '0; valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (empty !== 7'h7F) begin failures++; $display("FAIL reset_empty: got %h required 7f", empty); end
        checks++; if (full !== 7'h00 || mid !== 7'h00) begin failures++; $display("FAIL reset_full_mid: got %h/%h required 0/0", full, mid); end
        checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant: got %b required 0", grant); end
        checks++; if (last_ra !== '0) begin failures++; $display("FAIL reset_last_ra: got %h required 0", last_ra); end
        checks++; if (first_burst !== '0) begin failures++; $display("FAIL reset_first_burst: got %h required 0", first_burst); end
        checks++; if ({type_o, dq_o, idx_o, ra_o, ca_o} !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", {type_o, dq_o, idx_o, ra_o, ca_o}); end
    endtask

    task automatic test_push_fifo0();
        entry_t e0;
        e0 = mk(16'hAAAA, 6'd5, 16'h1234, 10'h3C5);
        op(7'h01, 7'h00, e0, 1'b1);
        checks++; if (empty[0] !== 1'b0) begin failures++; $display("FAIL f0_empty: got %b required 0", empty[0]); end
        checks++; if (last_ra[15:0] !== 16'h1234) begin failures++; $display("FAIL f0_last_ra: got %h required 1234", last_ra[15:0]); end
        checks++; if (first_burst[21:0] !== {16'h1234, 6'h3C}) begin failures++; $display("FAIL f0_first_burst: got %h required %h", first_burst[21:0], {16'h1234, 6'h3C}); end
        op(7'h00, 7'h01, e0, 1'b0);
        checks++; if (grant !== 1'b1 || ra_o !== 16'h1234) begin failures++; $display("FAIL f0_pop: got grant=%b ra=%h required 1/1234", grant, ra_o); end
        checks++; if (empty[0] !== 1'b1 || first_burst[21:0] !== '0) begin failures++; $display("FAIL f0_drained: got empty=%b fb=%h required 1/0", empty[0], first_burst[21:0]); end
        checks++; if (last_ra[15:0] !== 16'h1234) begin failures++; $display("FAIL f0_last_ra_kept: got %h required 1234", last_ra[15:0]); end
    endtask

    task automatic test_write_full();
        entry_t a, b, c;
        a = mk(16'hBEEF, 6'd1, 16'h4444, 10'h111);
        b = mk(16'hCAFE, 6'd2, 16'h5555, 10'h222);
        c = mk(16'hDEAD, 6'd3, 16'h6666, 10'h333);
        op(7'h10, 7'h00, a, 1'b1);
        checks++; if (mid[4] !== 1'b1 || full[4] !== 1'b0) begin failures++; $display("FAIL f4_one: got mid=%b full=%b required 1/0", mid[4], full[4]); end
        op(7'h10, 7'h00, b, 1'b1);
        checks++; if (mid[4] !== 1'b1 || full[4] !== 1'b1) begin failures++; $display("FAIL f4_two: got mid=%b full=%b required 1/1", mid[4], full[4]); end
        op(7'h10, 7'h00, c, 1'b1);
        checks++; if (full[4] !== 1'b1 || last_ra[64 +: 16] !== 16'h5555) begin failures++; $display("FAIL f4_drop: got full=%b last_ra=%h required 1/5555", full[4], last_ra[64 +: 16]); end
        op(7'h00, 7'h10, a, 1'b0);
        checks++; if (grant !== 1'b1 || type_o !== 1'b1 || dq_o !== 16'hBEEF) begin failures++; $display("FAIL f4_pop1: got grant=%b type=%b dq=%h required 1/1/beef", grant, type_o, dq_o); end
        op(7'h00, 7'h10, a, 1'b0);
        checks++; if (dq_o !== 16'hCAFE || empty[4] !== 1'b1) begin failures++; $display("FAIL f4_pop2: got dq=%h empty=%b required cafe/1", dq_o, empty[4]); end
        op(7'h00, 7'h10, a, 1'b0);
        checks++; if (grant !== 1'b0) begin failures++; $display("FAIL f4_pop_empty: got grant=%b required 0", grant); end
    endtask

    task automatic test_order_fifo1();
        entry_t e;
        for (int k = 0; k < 4; k++) begin
            e = mk(16'($urandom), 6'($urandom), 16'($urandom), 10'($urandom));
            op(7'h02, 7'h00, e, 1'b1);
            checks++; if (mid[1] !== (k >= 1)) begin failures++; $display("FAIL f1_mid_%0d: got %b required %b", k, mid[1], (k >= 1)); end
        end
        checks++; if (full[1] !== 1'b1) begin failures++; $display("FAIL f1_full: got %b required 1", full[1]); end
        for (int k = 0; k < 4; k++) begin
            op(7'h00, 7'h02, e, 1'b0);
            checks++; if (grant !== 1'b1 || type_o !== 1'b0) begin failures++; $display("FAIL f1_pop_%0d: got grant=%b type=%b required 1/0", k, grant, type_o); end
        end
        checks++; if (empty[1] !== 1'b1) begin failures++; $display("FAIL f1_empty: got %b required 1", empty[1]); end
    endtask

    task automatic test_pop_empty();
        logic [48:0] prev;
        entry_t      e;
        e = mk(16'h0, 6'h0, 16'h0, 10'h0);
        prev = {type_o, dq_o, idx_o, ra_o, ca_o};
        op(7'h00, 7'h04, e, 1'b0);
        checks++; if (grant !== 1'b0) begin failures++; $display("FAIL f2_grant: got %b required 0", grant); end
        checks++; if ({type_o, dq_o, idx_o, ra_o, ca_o} !== prev) begin failures++; $display("FAIL f2_hold: got %h required %h", {type_o, dq_o, idx_o, ra_o, ca_o}, prev); end
    endtask

    task automatic test_push_pop_full();
        entry_t a, b, c;
        a = mk(16'h1111, 6'd7, 16'h7001, 10'h0F1);
        b = mk(16'h2222, 6'd8, 16'h7002, 10'h0F2);
        c = mk(16'h3333, 6'd9, 16'h7003, 10'h0F3);
        op(7'h20, 7'h00, a, 1'b1);
        op(7'h20, 7'h00, b, 1'b1);
        op(7'h20, 7'h20, c, 1'b1);
        checks++; if (full[5] !== 1'b1 || grant !== 1'b1) begin failures++; $display("FAIL f5_push_pop: got full=%b grant=%b required 1/1", full[5], grant); end
        checks++; if (last_ra[80 +: 16] !== 16'h7003) begin failures++; $display("FAIL f5_last_ra: got %h required 7003", last_ra[80 +: 16]); end
        op(7'h00, 7'h20, a, 1'b0);
        op(7'h00, 7'h20, a, 1'b0);
        checks++; if (empty[5] !== 1'b1) begin failures++; $display("FAIL f5_empty: got %b required 1", empty[5]); end
    endtask

    task automatic test_empty_push_pop();
        entry_t e;
        e = mk(16'h4242, 6'd11, 16'h0BAD, 10'h2A5);
        op(7'h08, 7'h08, e, 1'b1);
        checks++; if (grant !== 1'b0 || empty[3] !== 1'b0) begin failures++; $display("FAIL f3_no_bypass: got grant=%b empty=%b required 0/0", grant, empty[3]); end
        op(7'h01, 7'h00, e, 1'b0);
        checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL valid_low: got empty0=%b required 1", empty[0]); end
        op(7'h00, 7'h08, e, 1'b0);
        checks++; if (grant !== 1'b1 || idx_o !== 6'd11) begin failures++; $display("FAIL f3_pop: got grant=%b idx=%h required 1/0b", grant, idx_o); end
    endtask

    task automatic test_back_to_back();
        entry_t e, f;
        e = mk(16'h5A5A, 6'd20, 16'hA001, 10'h155);
        f = mk(16'hA5A5, 6'd21, 16'hA002, 10'h2AA);
        op(7'h45, 7'h00, e, 1'b1);
        checks++; if (empty !== 7'h3A) begin failures++; $display("FAIL multi_push: got empty=%h required 3a", empty); end
        op(7'h02, 7'h00, f, 1'b1);
        op(7'h00, 7'h06, e, 1'b0);
        checks++; if (grant !== 1'b1 || ra_o !== 16'hA002) begin failures++; $display("FAIL pop_priority: got grant=%b ra=%h required 1/a002", grant, ra_o); end
        op(7'h00, 7'h01, e, 1'b0);
        op(7'h00, 7'h04, e, 1'b0);
        op(7'h00, 7'h40, e, 1'b0);
        checks++; if (empty !== 7'h7F || type_o !== 1'b1 || dq_o !== 16'h5A5A) begin failures++; $display("FAIL b2b_drain: got empty=%h type=%b dq=%h required 7f/1/5a5a", empty, type_o, dq_o); end
    endtask

    task automatic test_reset_mid();
        entry_t e;
        e = mk(16'h7777, 6'd30, 16'hC0DE, 10'h3FF);
        op(7'h51, 7'h00, e, 1'b1);
        checks++; if (empty !== 7'h2E) begin failures++; $display("FAIL pre_reset_fill: got empty=%h required 2e", empty); end
        rst_n = 1'b1;
        pop   = 7'h01;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pop   = '0;
        for (int i = 0; i < 7; i++) mq[i].delete();
        sb.delete();
        checks++; if (empty !== 7'h7F || grant !== 1'b0) begin failures++; $display("FAIL mid_reset: got empty=%h grant=%b required 7f/0", empty, grant); end
        checks++; if (last_ra !== '0 || first_burst !== '0) begin failures++; $display("FAIL mid_reset_rows: got last_ra=%h fb=%h required 0/0", last_ra, first_burst); end
        @(posedge clk);
        #2;
        checks++; if (grant !== 1'b0) begin failures++; $display("FAIL post_reset_grant: got %b required 0", grant); end
    endtask

    initial begin
        rst_n = 1'b1; push = '0; pop = '0; valid_i = 1'b0;
        dq_i = '0; idx_i = '0; ra_i = '0; ca_i = '0;
        test_reset();
        test_push_fifo0();
        test_write_full();
        test_order_fifo1();
        test_pop_empty();
        test_push_pop_full();
        test_empty_push_pop();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending pops required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
